sim_halt_monitor: RTL and testbench

SIM_HALT_MONITOR -- requirements
Module: sim_halt_monitor

---
 rtl/sim_halt_monitor.sv | 211 +++++++++++++++++++++
 tb/tb_sim_halt_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_halt_monitor.sv
// sim_halt_monitor
//   Watches the retire stream of a core under simulation and raises a sticky halt when the
//   retiring PC hits an enabled stop address, when the same PC retires STALL_LIMIT times in a
//   row, or when the RUN cycle budget is used up.
//
// Ports
//   clk, rstn       clock, asynchronous active-low reset
//   retire_i, pc_i  retire strobe and PC of the retiring instruction
//   stop_addr_i     NUM_STOP packed stop addresses, entry k at [k*XLEN +: XLEN]
//   stop_mask_i     per-entry enable for stop_addr_i
//   timeout_i       RUN cycle budget, 0 disables
//   clear_i         synchronous re-arm back to IDLE with everything zeroed
//   halt_o          sticky halt flag
//   halt_cause_o    0 none, 1 stop address, 2 stall, 3 timeout
//   halt_idx_o      matching stop entry (cause 1 only)
//   last_pc_o       PC of the most recent accepted retire
//   cycle_cnt_o     cycles spent in RUN (saturating)
//   retire_cnt_o    retires accepted in RUN (saturating)
//   trace_idx_i     (HALT_MONITOR_TRACE_EN only) trace entry to read, 0 = newest
//   trace_pc_o      (HALT_MONITOR_TRACE_EN only) PC stored in that trace entry
//
// Optional feature: define HALT_MONITOR_TRACE_EN to add a TRACE_DEPTH-entry ring buffer of
// accepted RUN retire PCs.

module sim_halt_monitor #(
    parameter int XLEN        = 32,
    parameter int NUM_STOP    = 2,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 16,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     retire_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [NUM_STOP*XLEN-1:0] stop_addr_i,
    input  logic [NUM_STOP-1:0]      stop_mask_i,
    input  logic [CNT_W-1:0]         timeout_i,
    input  logic                     clear_i,
`ifdef HALT_MONITOR_TRACE_EN
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
    output logic [XLEN-1:0]          trace_pc_o,
`endif
    output logic                     halt_o,
    output logic [1:0]               halt_cause_o,
    output logic [2:0]               halt_idx_o,
    output logic [XLEN-1:0]          last_pc_o,
    output logic [CNT_W-1:0]         cycle_cnt_o,
    output logic [CNT_W-1:0]         retire_cnt_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       STALL_LIM = 8'(STALL_LIMIT);

    // Elaboration-time parameter sanity checks
    if (NUM_STOP < 1 || NUM_STOP > 8) begin : g_bad_num_stop
        $error("NUM_STOP must be in 1..8");
    end
    if (STALL_LIMIT < 2 || STALL_LIMIT > 255) begin : g_bad_stall_limit
        $error("STALL_LIMIT must be in 2..255");
    end
    if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_trace_depth
        $error("TRACE_DEPTH must be a power of 2, at least 2");
    end

    logic [1:0]       r_state, w_state;
    logic [1:0]       r_cause, w_cause;
    logic [2:0]       r_idx, w_idx;
    logic [XLEN-1:0]  r_last_pc, w_last_pc;
    logic [CNT_W-1:0] r_cycle, w_cycle;
    logic [CNT_W-1:0] r_retire, w_retire;
    logic [7:0]       r_same, w_same;
    logic             w_accept;
    logic             w_active;
    logic             w_hit;
    logic [2:0]       w_hit_idx;

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = 3'd0;
        for (int k = NUM_STOP - 1; k >= 0; k--) begin
            if (stop_mask_i[k] && (stop_addr_i[k*XLEN +: XLEN] == pc_i)) begin
                w_hit     = 1'b1;
                w_hit_idx = 3'(k);
            end
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cause   = r_cause;
        w_idx     = r_idx;
        w_last_pc = r_last_pc;
        w_cycle   = r_cycle;
        w_retire  = r_retire;
        w_same    = r_same;
        w_accept  = 1'b0;
        w_active  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The start retire is itself accepted as retire 1 in cycle 1
                if (retire_i) begin
                    w_active  = 1'b1;
                    w_accept  = 1'b1;
                    w_state   = S_RUN;
                    w_cycle   = CNT_ONE;
                    w_retire  = CNT_ONE;
                    w_last_pc = pc_i;
                    w_same    = 8'd1;
                end
            end
            S_RUN: begin
                w_active = 1'b1;
                w_cycle  = (&r_cycle) ? r_cycle : r_cycle + CNT_ONE;
                if (retire_i) begin
                    w_accept  = 1'b1;
                    w_retire  = (&r_retire) ? r_retire : r_retire + CNT_ONE;
                    w_last_pc = pc_i;
                    w_same    = (pc_i == r_last_pc) ? r_same + 8'd1 : 8'd1;
                end
            end
            S_HALT: begin
            end
            default: w_state = S_IDLE;
        endcase

        // Priority: stop > stall > timeout
        if (w_active) begin
            if (w_accept && w_hit) begin
                w_state = S_HALT;
                w_cause = 2'd1;
                w_idx   = w_hit_idx;
            end else if (w_accept && (w_same == STALL_LIM)) begin
                w_state = S_HALT;
                w_cause = 2'd2;
            end else if ((timeout_i != '0) && (w_cycle == timeout_i)) begin
                w_state = S_HALT;
                w_cause = 2'd3;
            end
        end

        if (clear_i) begin
            w_state   = S_IDLE;
            w_cause   = 2'd0;
            w_idx     = 3'd0;
            w_last_pc = '0;
            w_cycle   = '0;
            w_retire  = '0;
            w_same    = 8'd0;
            w_accept  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_cause   <= 2'd0;
            r_idx     <= 3'd0;
            r_last_pc <= '0;
            r_cycle   <= '0;
            r_retire  <= '0;
            r_same    <= 8'd0;
        end else begin
            r_state   <= w_state;
            r_cause   <= w_cause;
            r_idx     <= w_idx;
            r_last_pc <= w_last_pc;
            r_cycle   <= w_cycle;
            r_retire  <= w_retire;
            r_same    <= w_same;
        end
    end

    assign halt_o       = (r_state == S_HALT);
    assign halt_cause_o = r_cause;
    assign halt_idx_o   = r_idx;
    assign last_pc_o    = r_last_pc;
    assign cycle_cnt_o  = r_cycle;
    assign retire_cnt_o = r_retire;

`ifdef HALT_MONITOR_TRACE_EN
    localparam int TAW = $clog2(TRACE_DEPTH);

    logic [XLEN-1:0] r_trace [TRACE_DEPTH];
    logic [TAW-1:0]  r_wptr;

    // w_accept is already low in HALT and under clear_i, so the buffer freezes there
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < TRACE_DEPTH; i++) r_trace[i] <= '0;
            r_wptr <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < TRACE_DEPTH; i++) r_trace[i] <= '0;
            r_wptr <= '0;
        end else if (w_accept) begin
            r_trace[r_wptr] <= pc_i;
            r_wptr          <= r_wptr + TAW'(1);
        end
    end

    // Newest entry sits just behind the write pointer; wrap is free at power-of-2 depth
    assign trace_pc_o = r_trace[r_wptr - TAW'(1) - trace_idx_i];
`endif

endmodule

// File: tb/tb_sim_halt_monitor.sv
module tb_sim_halt_monitor;

    localparam int XLEN     = 32;
    localparam int NUM_STOP = 2;
    localparam int CNT_W    = 32;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic                     retire_i;
    logic [XLEN-1:0]          pc_i;
    logic [NUM_STOP*XLEN-1:0] stop_addr_i;
    logic [NUM_STOP-1:0]      stop_mask_i;
    logic [CNT_W-1:0]         timeout_i;
    logic                     clear_i;
    logic                     halt_o;
    logic [1:0]               halt_cause_o;
    logic [2:0]               halt_idx_o;
    logic [XLEN-1:0]          last_pc_o;
    logic [CNT_W-1:0]         cycle_cnt_o;
    logic [CNT_W-1:0]         retire_cnt_o;
`ifdef HALT_MONITOR_TRACE_EN
    logic [2:0]               trace_idx_i;
    logic [XLEN-1:0]          trace_pc_o;
`endif

    sim_halt_monitor #(
        .XLEN        (XLEN),
        .NUM_STOP    (NUM_STOP),
        .CNT_W       (CNT_W),
        .STALL_LIMIT (4),
        .TRACE_DEPTH (8)
    ) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .retire_i     (retire_i),
        .pc_i         (pc_i),
        .stop_addr_i  (stop_addr_i),
        .stop_mask_i  (stop_mask_i),
        .timeout_i    (timeout_i),
        .clear_i      (clear_i),
`ifdef HALT_MONITOR_TRACE_EN
        .trace_idx_i  (trace_idx_i),
        .trace_pc_o   (trace_pc_o),
`endif
        .halt_o       (halt_o),
        .halt_cause_o (halt_cause_o),
        .halt_idx_o   (halt_idx_o),
        .last_pc_o    (last_pc_o),
        .cycle_cnt_o  (cycle_cnt_o),
        .retire_cnt_o (retire_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cause;
        logic [2:0]  idx;
        logic [31:0] pc;
        logic [31:0] rc;
        logic [31:0] cc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] cause, input logic [2:0] idx,
                            input logic [31:0] pc, input logic [31:0] rc, input logic [31:0] cc);
        exp_t e;
        e.cause = cause;
        e.idx   = idx;
        e.pc    = pc;
        e.rc    = rc;
        e.cc    = cc;
        exp_q.push_back(e);
    endtask

    // Bounded wait for halt, then pop the oldest expectation and compare
    task automatic expect_halt(input string tag);
        exp_t e;
        int   n = 0;
        while (!halt_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_halt"}, 64'(halt_o), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_cause"},  64'(halt_cause_o), 64'(e.cause));
            check({tag, "_idx"},    64'(halt_idx_o),   64'(e.idx));
            check({tag, "_lastpc"}, 64'(last_pc_o),    64'(e.pc));
            check({tag, "_retire"}, 64'(retire_cnt_o), 64'(e.rc));
            check({tag, "_cycle"},  64'(cycle_cnt_o),  64'(e.cc));
        end
    endtask

    task automatic retire(input logic [31:0] pc);
        retire_i = 1'b1;
        pc_i     = pc;
        @(posedge clk);
        #1;
        retire_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_halt"},   64'(halt_o),       64'd0);
        check({tag, "_cause"},  64'(halt_cause_o), 64'd0);
        check({tag, "_idx"},    64'(halt_idx_o),   64'd0);
        check({tag, "_lastpc"}, 64'(last_pc_o),    64'd0);
        check({tag, "_cycle"},  64'(cycle_cnt_o),  64'd0);
        check({tag, "_retire"}, 64'(retire_cnt_o), 64'd0);
    endtask

    initial begin
        rstn        = 1'b0;
        retire_i    = 1'b0;
        pc_i        = '0;
        stop_addr_i = '0;
        stop_mask_i = '0;
        timeout_i   = '0;
        clear_i     = 1'b0;
`ifdef HALT_MONITOR_TRACE_EN
        trace_idx_i = 3'd0;
`endif
        idle(2);
        check_zero("reset");
        rstn = 1'b1;
        idle(1);

        // Stop hit: entry 1 also matches but is masked off
        stop_addr_i = {32'h40, 32'h40};
        stop_mask_i = 2'b01;
        push_exp(2'd1, 3'd0, 32'h40, 32'd17, 32'd17);
        for (int n = 0; n < 16; n++) retire(32'(4 * n));
        check("stop_pre_halt", 64'(halt_o), 64'd0);
        retire(32'h40);
        expect_halt("stop");
        retire(32'h44);
        check("halt_frozen_retire", 64'(retire_cnt_o), 64'd17);
        check("halt_frozen_pc", 64'(last_pc_o), 64'h40);

        // Clear wins over a same-cycle retire
        clear_i  = 1'b1;
        retire_i = 1'b1;
        pc_i     = 32'h100;
        @(posedge clk);
        #1;
        clear_i  = 1'b0;
        retire_i = 1'b0;
        check_zero("clear");
        retire(32'h8);
        check("rearm_retire", 64'(retire_cnt_o), 64'd1);
        check("rearm_cycle", 64'(cycle_cnt_o), 64'd1);
        check("rearm_lastpc", 64'(last_pc_o), 64'h8);
        check("rearm_halt", 64'(halt_o), 64'd0);
        do_clear();

        // Stall with idle gaps between same-PC retires
        stop_mask_i = 2'b00;
        push_exp(2'd2, 3'd0, 32'h20, 32'd4, 32'd7);
        retire(32'h20);
        idle(1);
        retire(32'h20);
        idle(1);
        retire(32'h20);
        check("stall_pre_halt", 64'(halt_o), 64'd0);
        idle(1);
        retire(32'h20);
        expect_halt("stall");
        do_clear();

        // Stop and timeout coincide: stop wins
        timeout_i   = 32'd5;
        stop_addr_i = {32'h0, 32'h10};
        stop_mask_i = 2'b01;
        push_exp(2'd1, 3'd0, 32'h10, 32'd5, 32'd5);
        for (int n = 0; n < 5; n++) retire(32'(4 * n));
        expect_halt("prio_stop");
        do_clear();

        // Same stream with stops disabled: timeout
        stop_mask_i = 2'b00;
        push_exp(2'd3, 3'd0, 32'h10, 32'd5, 32'd5);
        for (int n = 0; n < 5; n++) retire(32'(4 * n));
        expect_halt("prio_tmo");
        do_clear();

        // Only entry 1 matches
        timeout_i   = '0;
        stop_addr_i = {32'h8, 32'h80};
        stop_mask_i = 2'b11;
        push_exp(2'd1, 3'd1, 32'h8, 32'd3, 32'd3);
        for (int n = 0; n < 3; n++) retire(32'(4 * n));
        expect_halt("stop_idx1");
        do_clear();

        // Timeout reached on idle cycles after a single retire
        stop_mask_i = 2'b00;
        timeout_i   = 32'd3;
        push_exp(2'd3, 3'd0, 32'h4, 32'd1, 32'd3);
        retire(32'h4);
        expect_halt("tmo_idle");
        do_clear();

        // Asynchronous reset mid-RUN
        timeout_i = '0;
        retire(32'h0);
        retire(32'h4);
        #2;
        rstn = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);
        check("post_rst_idle_cycle", 64'(cycle_cnt_o), 64'd0);
        retire(32'hc);
        check("post_rst_cycle", 64'(cycle_cnt_o), 64'd1);
        check("post_rst_retire", 64'(retire_cnt_o), 64'd1);

`ifdef HALT_MONITOR_TRACE_EN
        do_clear();
        trace_idx_i = 3'd0;
        #1;
        check("trace_empty", 64'(trace_pc_o), 64'd0);
        for (int n = 0; n < 10; n++) retire(32'(4 * n));
        trace_idx_i = 3'd0;
        #1;
        check("trace_idx0", 64'(trace_pc_o), 64'h24);
        trace_idx_i = 3'd7;
        #1;
        check("trace_idx7", 64'(trace_pc_o), 64'h8);
        trace_idx_i = 3'd2;
        #1;
        check("trace_idx2", 64'(trace_pc_o), 64'h1c);
`endif

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
